// File: rtl/alu_exec_unit.sv
// Multi-cycle execute unit: decodes ALUOp/Funct, runs single-cycle ops directly and shifts iteratively.
// Optional shift-add multiplier enabled by defining ALU_EXEC_MUL_EN.
module alu_exec_unit #(
    parameter int DATA_W     = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [3:0]        funct,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              busy
);
    localparam int SHAMT_W = $clog2(DATA_W);
    localparam logic [SHAMT_W:0] STEP_L = (SHAMT_W+1)'(SHIFT_STEP);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
        OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_MUL
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
`ifdef ALU_EXEC_MUL_EN
        , ST_MUL = 2'd3
`endif
    } state_e;

    function automatic op_e decode_op(input logic [1:0] aop, input logic [3:0] fn);
        op_e op;
        case (aop)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case (fn)
                    4'b0000: op = OP_ADD;
                    4'b1000: op = OP_SUB;
                    4'b0111: op = OP_AND;
                    4'b0110: op = OP_OR;
                    4'b0100: op = OP_XOR;
                    4'b0001: op = OP_SLL;
                    4'b0101: op = OP_SRL;
                    4'b1101: op = OP_SRA;
                    4'b0010: op = OP_SLT;
                    4'b0011: op = OP_SLTU;
                    default: op = OP_ADD;
                endcase
            end
`ifdef ALU_EXEC_MUL_EN
            2'b11: op = (fn == 4'b0000) ? OP_MUL : OP_ADD;
`endif
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

    state_e               state_r;
    op_e                  op_r;
    logic [DATA_W-1:0]    acc_r;
    logic [SHAMT_W-1:0]   rem_r;
    logic [DATA_W-1:0]    result_r;
    logic                 zero_r;
    logic                 out_valid_r;
    logic                 in_ready_r;
    logic                 busy_r;

    op_e                  op_s;
    logic [SHAMT_W-1:0]   shamt_s;
    logic                 is_shift_s;
    logic [DATA_W-1:0]    alu_s;
    logic [SHAMT_W:0]     step_s;
    logic [DATA_W-1:0]    shifted_s;
    logic [SHAMT_W-1:0]   rem_next_s;

    // Decode the incoming op and evaluate every single-cycle function on the live operands.
    always_comb begin
        op_s       = decode_op(alu_op, funct);
        shamt_s    = op_b[SHAMT_W-1:0];
        is_shift_s = (op_s == OP_SLL) || (op_s == OP_SRL) || (op_s == OP_SRA);
        case (op_s)
            OP_SUB:  alu_s = op_a - op_b;
            OP_AND:  alu_s = op_a & op_b;
            OP_OR:   alu_s = op_a | op_b;
            OP_XOR:  alu_s = op_a ^ op_b;
            OP_SLT:  alu_s = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_s = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            // A shift only lands here with a zero shift amount, so it passes op_a through.
            OP_SLL, OP_SRL, OP_SRA: alu_s = op_a;
            default: alu_s = op_a + op_b;
        endcase
    end

    // One shift iteration: at most SHIFT_STEP bits, the last step may be partial.
    always_comb begin
        if ({1'b0, rem_r} < STEP_L) begin
            step_s = {1'b0, rem_r};
        end else begin
            step_s = STEP_L;
        end
        case (op_r)
            OP_SLL:  shifted_s = acc_r << step_s;
            OP_SRL:  shifted_s = acc_r >> step_s;
            OP_SRA:  shifted_s = $signed(acc_r) >>> step_s;
            default: shifted_s = acc_r;
        endcase
        rem_next_s = rem_r - step_s[SHAMT_W-1:0];
    end

`ifdef ALU_EXEC_MUL_EN
    logic [DATA_W-1:0] mcand_r;
    logic [DATA_W-1:0] mplier_r;
    logic [DATA_W-1:0] mul_sum_s;

    // Shift-add partial product for the current multiplier bit.
    always_comb begin
        if (mplier_r[0]) begin
            mul_sum_s = acc_r + mcand_r;
        end else begin
            mul_sum_s = acc_r;
        end
    end
`endif

    // Control FSM with all handshake and result outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_ADD;
            acc_r       <= {DATA_W{1'b0}};
            rem_r       <= {SHAMT_W{1'b0}};
            result_r    <= {DATA_W{1'b0}};
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            mcand_r     <= {DATA_W{1'b0}};
            mplier_r    <= {DATA_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r       <= op_s;
                        acc_r      <= op_a;
                        rem_r      <= shamt_s;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (is_shift_s && (shamt_s != {SHAMT_W{1'b0}})) begin
                            state_r <= ST_SHIFT;
                        end
`ifdef ALU_EXEC_MUL_EN
                        else if (op_s == OP_MUL) begin
                            state_r  <= ST_MUL;
                            acc_r    <= {DATA_W{1'b0}};
                            mcand_r  <= op_a;
                            mplier_r <= op_b;
                            rem_r    <= SHAMT_W'(DATA_W - 1);
                        end
`endif
                        else begin
                            state_r     <= ST_DONE;
                            result_r    <= alu_s;
                            zero_r      <= (alu_s == {DATA_W{1'b0}});
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc_r <= shifted_s;
                    rem_r <= rem_next_s;
                    if (rem_next_s == {SHAMT_W{1'b0}}) begin
                        state_r     <= ST_DONE;
                        result_r    <= shifted_s;
                        zero_r      <= (shifted_s == {DATA_W{1'b0}});
                        out_valid_r <= 1'b1;
                    end
                end
`ifdef ALU_EXEC_MUL_EN
                ST_MUL: begin
                    acc_r    <= mul_sum_s;
                    mcand_r  <= {mcand_r[DATA_W-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[DATA_W-1:1]};
                    rem_r    <= rem_r - {{(SHAMT_W-1){1'b0}}, 1'b1};
                    if (rem_r == {SHAMT_W{1'b0}}) begin
                        state_r     <= ST_DONE;
                        result_r    <= mul_sum_s;
                        zero_r      <= (mul_sum_s == {DATA_W{1'b0}});
                        out_valid_r <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed scoreboard bench for alu_exec_unit (DATA_W=32, SHIFT_STEP=4).
module tb_alu_exec_unit;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [3:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    alu_exec_unit #(.DATA_W(32), .SHIFT_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one op at a negedge, waits for out_valid, compares against the scoreboard.
    task automatic run_op(input string tag, input logic [1:0] aop, input logic [3:0] fn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int exp_lat,
                          input bit disturb, input int hold);
        int lat;
        logic [31:0] e;
        logic [31:0] held;
        exp_q.push_back(exp_r);
        check({tag, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        alu_op = aop; funct = fn; op_a = a; op_b = b; in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (disturb) begin
                check({tag, ".busy"}, {31'd0, busy}, 32'd1);
                check({tag, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
                in_valid = 1'b1;
                op_a = $urandom;
                op_b = $urandom;
                alu_op = 2'b10;
                funct = 4'b0000;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, lat, exp_lat);
        e = exp_q.pop_front();
        check({tag, ".result"}, result, e);
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, (e == 32'd0)});
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".bp_result"}, result, held);
            check({tag, ".bp_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, ".bp_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".out_valid_clr"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".in_ready_ret"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int stray;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] re;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 2'b00; funct = 4'b0000; op_a = 32'd0; op_b = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.zero", {31'd0, zero}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);

        run_op("sub_5_7",   2'b10, 4'b1000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 1'b0, 0);
        run_op("br_sub",    2'b01, 4'b0000, 32'h1234, 32'h1234, 32'd0, 1, 1'b0, 0);
        run_op("slt",       2'b10, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1'b0, 0);
        run_op("sltu",      2'b10, 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b0, 0);
        run_op("f1111_add", 2'b10, 4'b1111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b0, 0);
        run_op("ls_add",    2'b00, 4'b1000, 32'h0000_0010, 32'h0000_0022, 32'h32, 1, 1'b0, 0);
        run_op("and",       2'b10, 4'b0111, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1, 1'b0, 0);
        run_op("or",        2'b10, 4'b0110, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1, 1'b0, 0);
        run_op("xor",       2'b10, 4'b0100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1, 1'b0, 0);
        run_op("sra9",      2'b10, 4'b1101, 32'h8000_0000, 32'd9, 32'hFFC0_0000, 4, 1'b1, 0);
        run_op("srl0",      2'b10, 4'b0101, 32'hDEAD_BEEF, 32'hFFFF_FF00, 32'hDEAD_BEEF, 1, 1'b0, 0);
        run_op("sll5",      2'b10, 4'b0001, 32'h0000_0003, 32'hFFFF_FFE5, 32'h0000_0060, 3, 1'b1, 0);
        run_op("srl31",     2'b10, 4'b0101, 32'h8000_0000, 32'd31, 32'd1, 9, 1'b0, 0);
        run_op("sra31",     2'b10, 4'b1101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 9, 1'b1, 0);
        run_op("sll4",      2'b10, 4'b0001, 32'h0000_0001, 32'd4, 32'h0000_0010, 2, 1'b0, 0);
        run_op("bp_hold",   2'b10, 4'b0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1, 1'b0, 5);
`ifdef ALU_EXEC_MUL_EN
        run_op("ext_mul",   2'b11, 4'b0000, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 33, 1'b0, 0);
`else
        run_op("ext_add",   2'b11, 4'b0000, 32'h0001_0001, 32'h0001_0001, 32'h0002_0002, 1, 1'b0, 0);
`endif
        run_op("ext_f1",    2'b11, 4'b0001, 32'h0000_0005, 32'h0000_0006, 32'h0000_000B, 1, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 3)
                0: begin re = ra + rb; run_op("rnd_add", 2'b10, 4'b0000, ra, rb, re, 1, 1'b0, 0); end
                1: begin re = ra - rb; run_op("rnd_sub", 2'b10, 4'b1000, ra, rb, re, 1, 1'b0, 0); end
                default: begin re = {31'd0, (ra < rb)}; run_op("rnd_sltu", 2'b10, 4'b0011, ra, rb, re, 1, 1'b0, 0); end
            endcase
        end

        // Reset in the middle of a 5-step shift must leave no output behind.
        alu_op = 2'b10; funct = 4'b0001; op_a = 32'd1; op_b = 32'd20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst.busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst.result", result, 32'd0);
        check("midrst.in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst.busy", {31'd0, busy}, 32'd0);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray++;
        end
        check("midrst.stray", stray, 32'd0);
        check("sb.empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
